// File: rtl/float_pkg.sv
// Shared float definitions for the sort controller and its comparator.
// Holds field widths, controller state encoding and field-slice helpers.
package float_pkg;

   localparam int FLOAT_W = 13;
   localparam int EXP_W   = 4;
   localparam int MAN_W   = 8;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_SORT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   function automatic logic f_sign(input logic [FLOAT_W-1:0] f);
      return f[FLOAT_W-1];
   endfunction

   function automatic logic [EXP_W-1:0] f_exp(input logic [FLOAT_W-1:0] f);
      return f[FLOAT_W-2 -: EXP_W];
   endfunction

   function automatic logic [MAN_W-1:0] f_man(input logic [FLOAT_W-1:0] f);
      return f[MAN_W-1:0];
   endfunction

   // Exponent above mantissa, so the magnitude compares as one unsigned word.
   function automatic logic [EXP_W+MAN_W-1:0] f_mag(input logic [FLOAT_W-1:0] f);
      return {f_exp(f), f_man(f)};
   endfunction

endpackage

// File: rtl/floating_greater.sv
// Combinational sign-magnitude float compare: gt = (a > b).
// Ports: a, b (FLOAT_W floats), gt. +0 orders above -0; equal -> gt=0.
module floating_greater
   import float_pkg::*;
(
   input  logic [FLOAT_W-1:0] a,
   input  logic [FLOAT_W-1:0] b,
   output logic               gt
);

   logic                   sa, sb;
   logic [EXP_W+MAN_W-1:0] ma, mb;

   assign sa = f_sign(a);
   assign sb = f_sign(b);
   assign ma = f_mag(a);
   assign mb = f_mag(b);

   always_comb begin
      gt = 1'b0;
      if (sa != sb) begin
         gt = sb;
      end else if (!sa) begin
         gt = (ma > mb);
      end else begin
         // Both negative: larger magnitude is the smaller value.
         gt = (ma < mb);
      end
   end

endmodule

// File: rtl/floating_sort_ctrl.sv
// Loads N floats, bubble-sorts them with one shared comparator, drains ascending.
// Ports: clk, reset_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_last, busy.
module floating_sort_ctrl
   import float_pkg::*;
#(
   parameter int N = 8,
   parameter int W = FLOAT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] PEN  = IDX_W'(N - 2);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] pass_q, pass_d;
   logic [IDX_W-1:0] nidx;
   logic [W-1:0]     mem_q [N];
   logic [W-1:0]     cmp_a, cmp_b;
   logic             gt;
   logic             wr_en;
   logic             swap;

   // Guard the neighbour index so idx=N-1 never reads past the buffer.
   assign nidx  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
   assign cmp_a = mem_q[idx_q];
   assign cmp_b = mem_q[nidx];

   floating_greater u_cmp (
      .a  (cmp_a),
      .b  (cmp_b),
      .gt (gt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_LOAD;
         idx_q   <= '0;
         pass_q  <= '0;
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         if (wr_en) mem_q[idx_q] <= in_data;
         if (swap) begin
            mem_q[idx_q] <= cmp_b;
            mem_q[nidx]  <= cmp_a;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = 1'b0;
      wr_en     = 1'b0;
      swap      = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  pass_d  = '0;
                  state_d = S_SORT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_SORT: begin
            busy = 1'b1;
            // Strict gt keeps equal values in input order.
            swap = gt;
            if (idx_q == PEN) begin
               idx_d = '0;
               if (pass_q == PEN) state_d = S_DRAIN;
               else pass_d = pass_q + 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = mem_q[idx_q];
            out_last  = (idx_q == LAST);
            if (out_ready) begin
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = S_LOAD;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

endmodule

// File: doc/floating_sort_ctrl.md
Name: floating_sort_ctrl

Overview:
Sequencing controller that accepts a block of N 13-bit floats over a valid/ready input stream and stores them in a register buffer. It sorts the buffer in ascending order using a single shared floating_greater comparator, one compare per clock. It then drains the sorted block over a valid/ready output stream. It sits between a sample source (switches, UART or similar) and a downstream consumer, and is the team's first sequential user of the floating comparator.

Parameters:
N, 8, number of floats per block; legal range 2..64.
W, 13, float width: sign [12], exponent [11:8], mantissa [7:0]; fixed by floating_greater.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_data holds a float.
in_ready  out  1  controller accepts in_data this cycle.
in_data  in  W  input float.
out_valid  out  1  out_data holds a sorted float.
out_ready  in  1  consumer accepts out_data this cycle.
out_data  out  W  sorted float, smallest first.
out_last  out  1  out_data is element N-1 of the block.
busy  out  1  high in SORT and DRAIN.

Behaviour:
- Reset (reset_n low, asynchronous): state=LOAD, idx=0, pass=0, all buffer entries 0. Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- Reset mid-operation discards the partial block. There is no flush output.
- Handshake rules for both ports:
  - A transfer occurs on a rising edge with valid&&ready.
  - The sender holds data stable while valid && !ready.
  - out_valid never drops without a transfer.
- LOAD state:
  - in_ready=1.
  - Each transfer writes buf[idx] and increments idx.
  - The transfer with idx==N-1 sets idx=0 and pass=0 and moves to SORT on the next cycle.
  - in_valid low stalls the state with no change.
- SORT state (fixed-length bubble sort):
  - in_ready=0, busy=1.
  - Each cycle, comparator a=buf[idx] and b=buf[idx+1].
  - If gt=1, the two entries swap at the clock edge. Otherwise no change.
  - idx runs 0..N-2. At idx==N-2, idx wraps to 0 and pass increments.
  - When pass==N-2 and idx==N-2, the next state is DRAIN with idx=0.
  - Duration is exactly (N-1)*(N-1) cycles with no early exit, so latency is deterministic.
  - gt=0 on equal operands gives a stable sort: equal values keep their input order.
- DRAIN state:
  - out_valid=1, out_data=buf[idx], out_last=(idx==N-1), busy=1.
  - Each output transfer increments idx.
  - The transfer with out_last=1 sets idx=0 and returns to LOAD; in_ready=1 on the next cycle.
  - out_ready low holds out_data and out_last stable.
- Latency:
  - The last input transfer to first out_valid is (N-1)^2 + 1 cycles.
  - Throughput is one block per N + (N-1)^2 + N cycles minimum.
- Inputs presented outside LOAD are not accepted. in_ready=0 there, so the source must hold them.
- Width rules:
  - idx width is $clog2(N); pass width is $clog2(N).
  - The comparison is combinational in floating_greater. The controller registers only the swap result.
- The controller performs no sign or exponent arithmetic. Ordering, including ±0, is exactly as floating_greater defines it.

Decomposition:
- Shared package float_pkg holds:
  - FLOAT_W=13, EXP_W=4, MAN_W=8.
  - State encoding constants S_LOAD, S_SORT, S_DRAIN.
  - The float field-slice helper functions.
- Single sub-module: the existing floating_greater, instantiated once as the shared comparator.
- The buffer and swap mux stay in floating_sort_ctrl. There is no separate sub-module.

Test Plan:
- Reset then idle: hold reset_n low mid-LOAD after 3 inputs, release → in_ready=1, out_valid=0, busy=0. The next N inputs form a fresh block.
- N=4 mixed signs: send 13'h0280, 13'h1180, 13'h0180, 13'h1280 → out 13'h1280, 13'h1180, 13'h0180, 13'h0280. out_last only on the 4th output.
- Latency, N=4: first out_valid exactly 10 cycles after the 4th input transfer. busy=1 from the cycle after that transfer.
- Already-sorted and reverse-sorted N=8 blocks → both produce ascending output in identical cycle counts (49 sort cycles).
- Stability: N=4 inputs 13'h0300, 13'h0300, 13'h0100, 13'h0300 tagged by order → 13'h0100 first, then the three 13'h0300 in original order. Check by monitoring swaps: none occur between equal operands.
- Backpressure: toggle out_ready randomly in DRAIN and in_valid in LOAD → no lost or duplicated element, data stable while stalled, and in_ready=0 throughout SORT and DRAIN.
